// File: rtl/regfile_sync_bypass_if.sv
// Register-file bus: decode read addresses, write-back write port, registered read data and ready.
interface regfile_sync_bypass_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              init_req;
   logic              rd_we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              ready;

   modport master (
      output init_req, rd_we, rd_addr, rd_data, rd_en, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, ready
   );

   modport slave (
      input  init_req, rd_we, rd_addr, rd_data, rd_en, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, ready
   );
endinterface

// File: rtl/regfile_sync_bypass.sv
// 2R1W register file with write-first bypass and hardware clear sweep; reads are 1-cycle registered.
// rd_en=0 holds the read outputs; all traffic is ignored while ready=0 (clear sweep in progress).
module regfile_sync_bypass #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32,
   parameter int ZERO_REG  = 1,
   localparam int ADDR_W   = (REG_COUNT > 2) ? $clog2(REG_COUNT) : 1
) (
   input logic                clk,
   input logic                rst_n,
   regfile_sync_bypass_if.slave bus
);
   localparam logic [0:0]        ST_INIT   = 1'b0;
   localparam logic [0:0]        ST_RUN    = 1'b1;
   localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(REG_COUNT);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_COUNT - 1);

   logic [DATA_W-1:0] mem [REG_COUNT];
   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_ok;
   logic [DATA_W-1:0] rs1_nxt;
   logic [DATA_W-1:0] rs2_nxt;

   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < REG_LIMIT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // A write colliding with init_req is dropped so the sweep starts from a clean file.
   assign wr_ok = (state == ST_RUN) && bus.rd_we && !bus.init_req && addr_live(bus.rd_addr);

   always_comb begin
      rs1_nxt = '0;
      if (addr_live(bus.rs1_addr)) begin
         if (wr_ok && (bus.rd_addr == bus.rs1_addr)) rs1_nxt = bus.rd_data;
         else                                         rs1_nxt = mem[bus.rs1_addr];
      end
   end

   always_comb begin
      rs2_nxt = '0;
      if (addr_live(bus.rs2_addr)) begin
         if (wr_ok && (bus.rd_addr == bus.rs2_addr)) rs2_nxt = bus.rd_data;
         else                                         rs2_nxt = mem[bus.rs2_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_INIT;
         clr_idx <= '0;
      end else if (state == ST_INIT) begin
         if (bus.init_req) begin
            clr_idx <= '0;
         end else if (clr_idx == LAST_IDX) begin
            state   <= ST_RUN;
            clr_idx <= '0;
         end else begin
            clr_idx <= clr_idx + 1'b1;
         end
      end else if (bus.init_req) begin
         state   <= ST_INIT;
         clr_idx <= '0;
      end
   end

   // Storage is deliberately unreset; the sweep establishes known contents.
   always_ff @(posedge clk) begin
      if (state == ST_INIT)  mem[clr_idx]     <= '0;
      else if (wr_ok)        mem[bus.rd_addr] <= bus.rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rs1_data <= '0;
         bus.rs2_data <= '0;
      end else if ((state == ST_INIT) || bus.init_req) begin
         bus.rs1_data <= '0;
         bus.rs2_data <= '0;
      end else if (bus.rd_en) begin
         bus.rs1_data <= rs1_nxt;
         bus.rs2_data <= rs2_nxt;
      end
   end

   assign bus.ready = (state == ST_RUN);
endmodule
